// File: rtl/rr_arbiter16_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter; no logic, no latency, no backpressure.
package rr_arbiter16_pkg;

    localparam int NUM_REQ = 16;
    localparam int ID_W    = 4;
    localparam int HOLD_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter16_pick.sv
// rr_pick: combinational first-set-bit search starting at i_ptr with wrap-around.
// Zero latency; no flow control, the caller decides when to use the pick.
module rr_pick
    import rr_arbiter16_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [ID_W-1:0]    o_pick_id,
    output logic               o_any_req
);

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_low;
    logic [2*NUM_REQ-1:0] w_low_dbl;
    logic [ID_W-1:0]      w_low_id;
    logic [ID_W:0]        w_back_base;

    // Rotate right so that bit 0 of w_rot is requester i_ptr.
    assign w_req_dbl = {i_req, i_req};
    assign w_rot     = w_req_dbl[i_ptr +: NUM_REQ];
    assign w_low     = w_rot & (-w_rot);

    always_comb begin
        w_low_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_low_id = ID_W'(k);
            end
        end
    end

    // Rotate the isolated bit back left by i_ptr.
    assign w_low_dbl   = {w_low, w_low};
    assign w_back_base = (ID_W+1)'(NUM_REQ) - {1'b0, i_ptr};
    assign o_pick      = w_low_dbl[w_back_base +: NUM_REQ];
    assign o_pick_id   = w_low_id + i_ptr;
    assign o_any_req   = |i_req;

endmodule

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter: registered one-hot grant one cycle after request, held until owner drops req,
// one dead cycle between grants. Optional tenure limit under RR_ARBITER16_TIMEOUT_EN.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_gnt_id;
    logic               r_gnt_valid;
    logic [ID_W-1:0]    r_ptr;

    state_t             w_nxt_state;
    logic [NUM_REQ-1:0] w_nxt_gnt;
    logic [ID_W-1:0]    w_nxt_gnt_id;
    logic               w_nxt_gnt_valid;
    logic [ID_W-1:0]    w_nxt_ptr;
    logic               w_release;

    logic [NUM_REQ-1:0] w_pick;
    logic [ID_W-1:0]    w_pick_id;
    logic               w_any_req;

`ifdef RR_ARBITER16_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_nxt_hold_cnt;
    logic              r_timeout;
    logic              w_nxt_timeout;
`else
    logic [HOLD_W-1:0] w_unused_max_hold;
    assign w_unused_max_hold = HOLD_W'(MAX_HOLD);
`endif

    rr_pick u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_pick    (w_pick),
        .o_pick_id (w_pick_id),
        .o_any_req (w_any_req)
    );

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_gnt       = r_gnt;
        w_nxt_gnt_id    = r_gnt_id;
        w_nxt_gnt_valid = r_gnt_valid;
        w_nxt_ptr       = r_ptr;
        w_release       = 1'b0;
`ifdef RR_ARBITER16_TIMEOUT_EN
        w_nxt_hold_cnt  = r_hold_cnt;
        w_nxt_timeout   = 1'b0;
`endif
        case (r_state)
            IDLE, RELEASE: begin
                if (enable && w_any_req) begin
                    w_nxt_state     = GRANT;
                    w_nxt_gnt       = w_pick;
                    w_nxt_gnt_id    = w_pick_id;
                    w_nxt_gnt_valid = 1'b1;
`ifdef RR_ARBITER16_TIMEOUT_EN
                    w_nxt_hold_cnt  = '0;
`endif
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            GRANT: begin
                w_release = !req[r_gnt_id];
`ifdef RR_ARBITER16_TIMEOUT_EN
                // An owner drop on the limit cycle wins: normal release, no timeout pulse.
                if (!w_release && r_hold_cnt == HOLD_LIMIT) begin
                    w_release     = 1'b1;
                    w_nxt_timeout = 1'b1;
                end else if (!w_release) begin
                    w_nxt_hold_cnt = r_hold_cnt + 1'b1;
                end
`endif
                if (w_release) begin
                    w_nxt_state     = RELEASE;
                    w_nxt_gnt       = '0;
                    w_nxt_gnt_id    = '0;
                    w_nxt_gnt_valid = 1'b0;
                    w_nxt_ptr       = r_gnt_id + 1'b1;
                end
            end
            default: begin
                w_nxt_state     = IDLE;
                w_nxt_gnt       = '0;
                w_nxt_gnt_id    = '0;
                w_nxt_gnt_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_gnt       <= w_nxt_gnt;
            r_gnt_id    <= w_nxt_gnt_id;
            r_gnt_valid <= w_nxt_gnt_valid;
            r_ptr       <= w_nxt_ptr;
        end
    end

`ifdef RR_ARBITER16_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_nxt_hold_cnt;
            r_timeout  <= w_nxt_timeout;
        end
    end
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule
